// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Defining UART_RX_PARITY_EN adds the parity state to the receiver enum.
package uart_pkg;

  localparam int          OVERSAMPLE    = 16;
  localparam int          SAMPLE_MID    = 7;
  localparam logic [31:0] RX_EMPTY_WORD = 32'hFFFF_FFFF;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_WAIT_IDLE
  } rx_state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_WAIT_IDLE
  } rx_state_t;
`endif

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO is accepted only when a pop
// happens in the same cycle, otherwise it is silently discarded.
module sync_fifo #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 16,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_rx.sv
// Buffered 16x-oversampling UART receiver feeding the bus-side data register.
// Optional macro UART_RX_PARITY_EN switches the frame to 8E1 and adds parity_err.
module uart_rx import uart_pkg::*; #(
  parameter  int BAUD_DIV   = 27,
  parameter  int FIFO_DEPTH = 16,
  localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx,
  input  logic          re,
  input  logic          clr_err,
  output logic [31:0]   rdata,
  output logic          avail,
  output logic [CW-1:0] count,
  output logic          overrun,
  output logic          frame_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic          parity_err
`endif
);

  logic        rx_p0;
  logic        rx_p1;
  logic        rx_p2;
  logic [15:0] baud_cnt;
  logic        tick;
  rx_state_t   state;
  logic [3:0]  tc;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic        fall;
  logic        end_hit;
  logic        stop_ok;
  logic        push;
  logic        frame_evt;
  logic        ovf_evt;
  logic [7:0]  fifo_dout;
  logic        fifo_full;
  logic        fifo_empty;

  // Stage boundary: p0/p1 synchronize the pad, p2 is history for edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
      rx_p2 <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_p1 <= rx_p0;
      rx_p2 <= rx_p1;
    end
  end

  assign fall = rx_p2 && !rx_p1;

  // Free-running oversample tick; deliberately never re-phased to the start edge.
  assign tick = (baud_cnt == 16'(BAUD_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst)       baud_cnt <= '0;
    else if (tick) baud_cnt <= '0;
    else           baud_cnt <= baud_cnt + 1'b1;
  end

  assign end_hit   = tick && (tc == 4'(OVERSAMPLE - 1));
  assign stop_ok   = (state == ST_STOP) && end_hit && rx_p1;
  assign frame_evt = (state == ST_STOP) && end_hit && !rx_p1;

`ifdef UART_RX_PARITY_EN
  logic par_bad;
  logic parity_evt;

  always_ff @(posedge clk) begin
    if (state == ST_PARITY && end_hit) par_bad <= ^{shift, rx_p1};
  end

  assign push       = stop_ok && !par_bad;
  assign parity_evt = stop_ok && par_bad;
`else
  assign push = stop_ok;
`endif

  always_ff @(posedge clk) begin
    if (state == ST_DATA && end_hit) shift <= {rx_p1, shift[7:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      tc      <= '0;
      bit_idx <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fall) begin
            tc    <= '0;
            state <= ST_START;
          end
        end
        ST_START: begin
          if (tick) begin
            if (tc == 4'(SAMPLE_MID)) begin
              tc      <= '0;
              bit_idx <= '0;
              state   <= rx_p1 ? ST_IDLE : ST_DATA;
            end else begin
              tc <= tc + 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            tc <= tc + 1'b1;
            if (tc == 4'(OVERSAMPLE - 1)) begin
              bit_idx <= bit_idx + 1'b1;
`ifdef UART_RX_PARITY_EN
              if (bit_idx == 3'd7) state <= ST_PARITY;
`else
              if (bit_idx == 3'd7) state <= ST_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (tick) begin
            tc <= tc + 1'b1;
            if (tc == 4'(OVERSAMPLE - 1)) state <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (tick) begin
            tc <= tc + 1'b1;
            if (tc == 4'(OVERSAMPLE - 1)) state <= rx_p1 ? ST_IDLE : ST_WAIT_IDLE;
          end
        end
        ST_WAIT_IDLE: begin
          if (rx_p1) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  sync_fifo #(
    .DATA_W (8),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (shift),
    .pop   (re),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  // A simultaneous pop frees a slot, so a push into a full FIFO is only lost without re.
  assign ovf_evt = push && fifo_full && !re;

  assign rdata = fifo_empty ? RX_EMPTY_WORD : {24'h0, fifo_dout};
  assign avail = !fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (ovf_evt)      overrun <= 1'b1;
      else if (clr_err) overrun <= 1'b0;
      if (frame_evt)    frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst)             parity_err <= 1'b0;
    else if (parity_evt) parity_err <= 1'b1;
    else if (clr_err)    parity_err <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed-plus-random bench for uart_rx (default 8N1 build) against a queue model.
module tb_uart_rx;

  localparam int BAUD     = 4;
  localparam int DEPTH    = 16;
  localparam int BIT_CYC  = 16 * BAUD;
  localparam int PUSH_OFS = (8 + 16 * 9 - 1) * BAUD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx = 1'b1;
  logic        re = 1'b0;
  logic        clr_err = 1'b0;
  logic [31:0] rdata;
  logic        avail;
  logic [4:0]  count;
  logic        overrun;
  logic        frame_err;

  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  model_q[$];
  logic        model_ovr = 1'b0;
  logic        model_ferr = 1'b0;

  uart_rx #(.BAUD_DIV(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .re        (re),
    .clr_err   (clr_err),
    .rdata     (rdata),
    .avail     (avail),
    .count     (count),
    .overrun   (overrun),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  // Between edge n-1 and edge n this holds n, where edge 0 is the first with rst low.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_head();
    if (model_q.size() == 0) return 32'hFFFF_FFFF;
    return {24'h0, model_q[0]};
  endfunction

  task automatic check_state(input string tag);
    @(negedge clk);
    check({tag, "_rdata"}, rdata, exp_head());
    check({tag, "_count"}, 32'(count), 32'(model_q.size()));
    check({tag, "_avail"}, 32'(avail), 32'(model_q.size() != 0));
    check({tag, "_ovr"},   32'(overrun), 32'(model_ovr));
    check({tag, "_ferr"},  32'(frame_err), 32'(model_ferr));
  endtask

  task automatic tick_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int unsigned n);
    check("sched", 32'(cyc <= n), 32'd1);
    while (cyc < n) tick_edge();
  endtask

  task automatic model_push(input logic [7:0] b);
    if (model_q.size() < DEPTH) model_q.push_back(b);
    else                        model_ovr = 1'b1;
  endtask

  // Drives start + 8 data bits and leaves the stop bit on the line; returns the
  // edge index at which the receiver samples the stop bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, output int unsigned pe);
    int unsigned t1;
    tick_edge();
    rx = 1'b0;
    t1 = cyc + 3;
    while (t1 % BAUD != BAUD - 1) t1++;
    pe = t1 + PUSH_OFS;
    for (int i = 0; i < 8; i++) begin
      repeat (BIT_CYC) @(posedge clk);
      #1;
      rx = b[i];
    end
    repeat (BIT_CYC) @(posedge clk);
    #1;
    rx = stop_bit;
  endtask

  task automatic finish_frame(input int unsigned pe, input logic pop_now);
    wait_until(pe);
    re = pop_now;
    tick_edge();
    re = 1'b0;
    repeat (32) tick_edge();
    rx = 1'b1;
    repeat (4) tick_edge();
  endtask

  task automatic recv(input logic [7:0] b);
    int unsigned pe;
    send_frame(b, 1'b1, pe);
    finish_frame(pe, 1'b0);
    model_push(b);
  endtask

  task automatic pop(input int n);
    re = 1'b1;
    repeat (n) begin
      tick_edge();
      if (model_q.size() != 0) void'(model_q.pop_front());
    end
    re = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    tick_edge();
    clr_err = 1'b0;
    model_ovr  = 1'b0;
    model_ferr = 1'b0;
  endtask

  initial begin
    int unsigned pe;
    logic [7:0]  b;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_state("reset");

    // Single byte with exact push-edge latency.
    send_frame(8'h55, 1'b1, pe);
    wait_until(pe);
    @(negedge clk);
    check("pre_push_avail", 32'(avail), 32'd0);
    tick_edge();
    @(negedge clk);
    check("push55_rdata", rdata, 32'h0000_0055);
    check("push55_avail", 32'(avail), 32'd1);
    model_push(8'h55);
    repeat (32) tick_edge();
    rx = 1'b1;
    repeat (4) tick_edge();
    pop(1);
    check_state("pop55");

    pop(2);
    check_state("empty_pop");

    // Glitch of 3 ticks must not start a frame.
    tick_edge();
    rx = 1'b0;
    repeat (3 * BAUD) tick_edge();
    rx = 1'b1;
    repeat (100) tick_edge();
    check_state("glitch");
    b = 8'($urandom);
    recv(b);
    check_state("after_glitch");
    pop(1);

    // Framing error, clear, then clean reception.
    send_frame(8'hA5, 1'b0, pe);
    finish_frame(pe, 1'b0);
    model_ferr = 1'b1;
    check_state("frame");
    pulse_clr();
    check_state("clr_ferr");
    recv(8'h3C);
    check_state("after_frame");
    pop(1);
    check_state("pop3c");

    // Random bytes with random-length pop bursts.
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      recv(b);
      check_state("rand_rx");
      if ($urandom_range(0, 1) == 1) begin
        pop($urandom_range(1, 4));
        check_state("rand_pop");
      end
    end
    pop(DEPTH + 2);
    check_state("drain");

    // Overrun: 17 bytes into a 16-deep FIFO.
    for (int i = 0; i <= 16; i++) recv(8'(i));
    check_state("overrun");
    for (int i = 0; i < 17; i++) begin
      pop(1);
      check_state("ovr_pop");
    end
    pulse_clr();
    check_state("clr_ovr");

    // Full FIFO with a pop on the very push edge of 0x77.
    for (int i = 0; i < DEPTH; i++) recv(8'($urandom));
    check_state("full");
    send_frame(8'h77, 1'b1, pe);
    finish_frame(pe, 1'b1);
    void'(model_q.pop_front());
    model_q.push_back(8'h77);
    check_state("simul");
    for (int i = 0; i < DEPTH; i++) begin
      check_state("simul_head");
      pop(1);
    end
    check_state("simul_empty");

    // Reset in the middle of a 0xFF frame empties the FIFO and abandons the frame.
    recv(8'($urandom));
    recv(8'($urandom));
    tick_edge();
    rx = 1'b0;
    repeat (BIT_CYC) tick_edge();
    rx = 1'b1;
    repeat (3 * BIT_CYC) tick_edge();
    rst = 1'b1;
    repeat (3) tick_edge();
    rst = 1'b0;
    model_q.delete();
    model_ovr  = 1'b0;
    model_ferr = 1'b0;
    repeat (8 * BIT_CYC) tick_edge();
    check_state("rst_mid");
    b = 8'($urandom);
    recv(b);
    check_state("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
